// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller for the synchronous FIFO family.
// Owns the speculative write pointer and gates pushes against a full
// condition taken from the same-clock read pointer. Drives a registered
// memory write port. Publishes a Gray-coded committed pointer that trails
// the speculative pointer by one cycle, so the read side only ever sees
// entries whose memory write has already landed.
module fifo_wr_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [1:0]        state
);

  localparam int            DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_FULL = 2'd2
  } state_e;

  // Binary to reflected Gray code; adjacent pointer values differ in one bit.
  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   gray_q, gray_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  state_e            state_q;
  logic              accept;
  logic              ovf_set;

  // The extra MSB of both pointers keeps full (difference DEPTH) apart
  // from empty (difference 0).
  assign wr_count    = wr_ptr_q - rd_ptr;
  assign full        = (wr_count == DEPTH_C);
  assign almost_full = (wr_count >= AFULL_C);

  // Flush outranks everything; a push while full only marks overflow.
  assign accept  = wr_en & ~full & ~flush;
  assign ovf_set = wr_en &  full & ~flush;

  // Next-state for pointers, the memory write port and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    gray_d   = bin2gray(wr_ptr_q);
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = rd_ptr;
      gray_d   = bin2gray(rd_ptr);
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      we_d     = 1'b1;
      addr_d   = wr_ptr_q[ADDR_W-1:0];
      wdata_d  = wr_data;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Register pointers and write port; arst drops an in-flight write immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      gray_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      gray_q   <= gray_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
    end
  end

  // Observational FSM tracking what the controller did on the last edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
    end else begin
      if (flush) begin
        state_q <= S_IDLE;
      end else if (accept) begin
        state_q <= S_PUSH;
      end else if (full) begin
        state_q <= S_FULL;
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign overflow    = ovf_q;
  assign wr_ptr_gray = gray_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ADDR_W=4, DATA_W=8, AFULL_TH=12.
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic [4:0] rd_ptr;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;
  logic [4:0] wr_ptr_gray;
  logic [1:0] state;

  int errs   = 0;
  int checks = 0;

  fifo_wr_ctrl #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(12)) dut (
    .clk(clk), .arst(arst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_ovf(clr_ovf), .rd_ptr(rd_ptr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow), .wr_ptr_gray(wr_ptr_gray),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] m_wp;
  logic [4:0] prev_g;
  int         wraps;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0; rd_ptr = 5'd0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_gray", wr_ptr_gray, 0);
    chk("rst_state", state, 0);
    step();
    arst = 1'b0;

    // Fill: 16 pushes, data 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      chk("fill_we", mem_we, 1);
      chk("fill_addr", mem_addr, i);
      chk("fill_data", mem_wdata, i);
      chk("fill_count", wr_count, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      chk("fill_state", state, 1);
      chk("fill_gray", wr_ptr_gray, g(5'(i)));
    end
    chk("fill_full", full, 1);
    wr_en = 1'b0;
    step();
    chk("full_we", mem_we, 0);
    chk("full_state", state, 2);
    chk("full_count", wr_count, 16);
    chk("full_gray", wr_ptr_gray, 5'h18);

    // Pushes while full set a sticky overflow
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hEE;
      step();
      chk("ovf_we", mem_we, 0);
      chk("ovf_count", wr_count, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_addr", mem_addr, 15);
      chk("ovf_state", state, 2);
    end
    wr_en = 1'b0; clr_ovf = 1'b1;
    step();
    chk("clr_ovf", overflow, 0);
    wr_en = 1'b1;
    step();
    chk("ovf_set_wins", overflow, 1);
    wr_en = 1'b0;
    step();
    chk("clr_ovf2", overflow, 0);
    clr_ovf = 1'b0;

    // Free one slot: exactly one push admitted, to address 0
    rd_ptr = 5'd1; wr_en = 1'b1; wr_data = 8'hA5;
    step();
    chk("slot_we", mem_we, 1);
    chk("slot_addr", mem_addr, 0);
    chk("slot_data", mem_wdata, 8'hA5);
    chk("slot_count", wr_count, 16);
    chk("slot_full", full, 1);
    chk("slot_state", state, 1);
    step();
    chk("slot_block_we", mem_we, 0);
    chk("slot_block_ovf", overflow, 1);
    chk("slot_block_state", state, 2);
    chk("slot_gray", wr_ptr_gray, g(5'd17));

    // Burst, then flush with rd_ptr=5
    rd_ptr = 5'd5; wr_data = 8'h11;
    step();
    chk("burst_we", mem_we, 1);
    chk("burst_addr", mem_addr, 1);
    chk("burst_count", wr_count, 13);
    chk("burst_afull", almost_full, 1);
    flush = 1'b1;
    step();
    chk("flush_count", wr_count, 0);
    chk("flush_we", mem_we, 0);
    chk("flush_state", state, 0);
    chk("flush_ovf_kept", overflow, 1);
    chk("flush_gray", wr_ptr_gray, 5'd7);
    chk("flush_afull", almost_full, 0);
    flush = 1'b0; wr_data = 8'h3C;
    step();
    chk("post_flush_addr", mem_addr, 5);
    chk("post_flush_data", mem_wdata, 8'h3C);
    chk("post_flush_count", wr_count, 1);

    // 40 interleaved push/pop; rd_ptr keeps 8 entries behind
    m_wp = 5'd6; prev_g = 5'd7; wraps = 0;
    for (int i = 0; i < 40; i++) begin
      rd_ptr = m_wp - 5'd8; wr_en = 1'b1; wr_data = 8'(i + 64);
      step();
      chk("il_we", mem_we, 1);
      chk("il_addr", mem_addr, m_wp[3:0]);
      chk("il_data", mem_wdata, i + 64);
      chk("il_count", wr_count, 9);
      chk("il_gray", wr_ptr_gray, g(m_wp));
      chk("il_gray_1bit", $countones(wr_ptr_gray ^ prev_g), 1);
      if (mem_addr == 4'd0) wraps++;
      prev_g = wr_ptr_gray;
      m_wp = m_wp + 5'd1;
    end
    chk("il_wraps", wraps, 2);
    wr_en = 1'b0;
    step();
    chk("il_idle_we", mem_we, 0);
    chk("il_idle_state", state, 0);
    chk("il_idle_count", wr_count, 9);
    chk("il_gray_lag", wr_ptr_gray, g(m_wp));

    // Asynchronous reset in the middle of a push
    wr_en = 1'b1; wr_data = 8'h99;
    step();
    chk("pre_arst_we", mem_we, 1);
    #2;
    arst = 1'b1; rd_ptr = 5'd0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_wdata, 0);
    chk("arst_gray", wr_ptr_gray, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_state", state, 0);
    chk("arst_count", wr_count, 0);
    step();
    chk("arst_hold_we", mem_we, 0);
    arst = 1'b0; wr_data = 8'h77;
    step();
    chk("restart_we", mem_we, 1);
    chk("restart_addr", mem_addr, 0);
    chk("restart_data", mem_wdata, 8'h77);
    chk("restart_count", wr_count, 1);
    wr_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
